// File: rtl/skew_rd_control.sv
// Diagonal-skew read sequencer: lane i of the memory array reads rows B..B+L-1,
// starting i cycles after lane 0, followed by a delayed output-write window.
module skew_rd_control #(
    parameter int width_height = 16,
    parameter int addr_width   = 8,
    parameter int wr_lat       = width_height + 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               active,
    input  logic [addr_width-1:0]              base_addr,
    input  logic [addr_width-1:0]              len,
    input  logic                               stall,
    output logic [width_height-1:0]            rd_en,
    output logic [width_height*addr_width-1:0] rd_addr,
    output logic                               wr_active,
    output logic                               busy,
    output logic                               done
);

    // The step counter must reach wr_lat + L + width_height - 2 for the largest L.
    localparam int cnt_width = $clog2(wr_lat + (1 << addr_width) + width_height + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_reg, state_next;
    logic [cnt_width-1:0]  t_reg, t_next;
    logic [addr_width-1:0] base_reg, base_next;
    logic [addr_width-1:0] len_reg, len_next;
    logic [cnt_width-1:0]  last;
    logic                  run_go;

    assign last = cnt_width'(wr_lat) + cnt_width'(len_reg)
                + cnt_width'(width_height) - cnt_width'(2);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            t_reg     <= '0;
            base_reg  <= '0;
            len_reg   <= '0;
        end else begin
            state_reg <= state_next;
            t_reg     <= t_next;
            base_reg  <= base_next;
            len_reg   <= len_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        t_next     = t_reg;
        base_next  = base_reg;
        len_next   = len_reg;
        case (state_reg)
            IDLE: begin
                if (active && (len != '0)) begin
                    state_next = RUN;
                    t_next     = '0;
                    base_next  = base_addr;
                    len_next   = len;
                end
            end
            RUN: begin
                if (!stall) begin
                    if (t_reg == last) begin
                        state_next = DONE;
                    end else begin
                        t_next = t_reg + cnt_width'(1);
                    end
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign run_go = (state_reg == RUN) && !stall;

    // Each lane sees the same row sequence, delayed by its lane index.
    generate
        for (genvar gi = 0; gi < width_height; gi++) begin : g_lane
            logic [cnt_width-1:0] offset;
            logic                 in_window;

            assign offset    = t_reg - cnt_width'(gi);
            assign in_window = (t_reg >= cnt_width'(gi)) && (offset < cnt_width'(len_reg));
            assign rd_en[gi] = run_go && in_window;
            assign rd_addr[gi*addr_width +: addr_width] =
                rd_en[gi] ? (base_reg + offset[addr_width-1:0]) : '0;
        end
    endgenerate

    assign wr_active = run_go && (t_reg >= cnt_width'(wr_lat)) && (t_reg <= last);
    assign busy      = (state_reg == RUN);
    assign done      = (state_reg == DONE);

endmodule

// File: tb/tb_skew_rd_control.sv
// Bench for skew_rd_control (4 lanes, 8-bit addresses, write latency 5): a fixed
// vector table, hand-built corner sequences and random traffic against a model.
module tb_skew_rd_control;

    localparam int WH = 4;
    localparam int AW = 8;
    localparam int WL = 5;

    logic            clk = 1'b0;
    logic            reset, active, stall;
    logic [AW-1:0]   base_addr, len;
    logic [WH-1:0]   rd_en;
    logic [WH*AW-1:0] rd_addr;
    logic            wr_active, busy, done;

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    // reference model state
    bit m_run, m_done;
    int m_t, m_b, m_l;

    skew_rd_control #(.width_height(WH), .addr_width(AW), .wr_lat(WL)) dut (
        .clk(clk), .reset(reset), .active(active), .base_addr(base_addr),
        .len(len), .stall(stall), .rd_en(rd_en), .rd_addr(rd_addr),
        .wr_active(wr_active), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       act;
        logic [7:0] b;
        logic [7:0] l;
        logic       st;
        logic       rst;
        logic [3:0] en;
        logic [7:0] a0;
        logic [7:0] a3;
        logic       wr;
        logic       bz;
        logic       dn;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp)
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, got, exp);
        else
            passes++;
    endtask

    task automatic drive(input logic a, input logic [7:0] b, input logic [7:0] l,
                         input logic s, input logic r);
        active = a; base_addr = b; len = l; stall = s; reset = r;
        #2;
    endtask

    task automatic check_model();
        logic [WH-1:0]    e_en;
        logic [WH*AW-1:0] e_addr;
        logic             e_wr;
        e_en = '0;
        e_addr = '0;
        if (m_run && !stall) begin
            for (int i = 0; i < WH; i++) begin
                if (m_t >= i && m_t < i + m_l) begin
                    e_en[i] = 1'b1;
                    e_addr[i*AW +: AW] = 8'((m_b + m_t - i) % 256);
                end
            end
        end
        e_wr = m_run && !stall && (m_t >= WL) && (m_t <= WL + m_l + WH - 2);
        chk("model_rd_en", 64'(rd_en), 64'(e_en));
        chk("model_rd_addr", 64'(rd_addr), 64'(e_addr));
        chk("model_wr_active", 64'(wr_active), 64'(e_wr));
        chk("model_busy", 64'(busy), 64'(m_run));
        chk("model_done", 64'(done), 64'(m_done));
    endtask

    task automatic edge_step();
        @(posedge clk);
        if (reset) begin
            m_run = 0; m_done = 0; m_t = 0; m_b = 0; m_l = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_run) begin
            if (!stall) begin
                if (m_t == WL + m_l + WH - 2) begin
                    m_run = 0; m_done = 1;
                end else begin
                    m_t++;
                end
            end
        end else if (active && len != 0) begin
            m_run = 1; m_t = 0; m_b = int'(base_addr); m_l = int'(len);
        end
        cyc++;
        #1;
    endtask

    task automatic step();
        check_model();
        edge_step();
    endtask

    task automatic cycle(input logic a, input logic [7:0] b, input logic [7:0] l,
                         input logic s, input logic r);
        drive(a, b, l, s, r);
        step();
    endtask

    // Idles the inputs until done appears; checks its cycle distance from start.
    task automatic wait_done(input int start_c, input int exp_lat, input string nm);
        for (int k = 0; k < 400; k++) begin
            drive(0, 0, 0, 0, 0);
            if (done) begin
                chk(nm, 64'(cyc - start_c), 64'(exp_lat));
                step();
                return;
            end
            step();
        end
        chk({nm, "_timeout"}, 64'(0), 64'(1));
    endtask

    initial begin
        int sc, wcount, k, rise1, rise2, done1;
        logic prev_busy;

        tbl[0]  = '{1'b1, 8'h10, 8'd3, 1'b0, 1'b0, 4'b0000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 8'h00, 8'd0, 1'b0, 1'b0, 4'b0001, 8'h10, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 8'h00, 8'd0, 1'b0, 1'b0, 4'b0011, 8'h11, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 8'h00, 8'd0, 1'b0, 1'b0, 4'b0111, 8'h12, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 8'h00, 8'd0, 1'b0, 1'b0, 4'b1110, 8'h00, 8'h10, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 8'h00, 8'd0, 1'b0, 1'b0, 4'b1100, 8'h00, 8'h11, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 8'h00, 8'd0, 1'b0, 1'b0, 4'b1000, 8'h00, 8'h12, 1'b1, 1'b1, 1'b0};
        for (int i = 7; i < 12; i++)
            tbl[i] = '{1'b0, 8'h00, 8'd0, 1'b0, 1'b0, 4'b0000, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 8'h00, 8'd0, 1'b0, 1'b0, 4'b0000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 8'h00, 8'd0, 1'b0, 1'b0, 4'b0000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};

        // reset, with a competing start request that must lose
        drive(1, 8'h33, 8'd2, 0, 1);
        edge_step();
        drive(0, 0, 0, 0, 1);
        edge_step();
        drive(0, 0, 0, 0, 0);
        chk("reset_rd_en", 64'(rd_en), 64'(0));
        chk("reset_rd_addr", 64'(rd_addr), 64'(0));
        chk("reset_wr_active", 64'(wr_active), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        step();

        // basic run from the vector table
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].act, tbl[i].b, tbl[i].l, tbl[i].st, tbl[i].rst);
            chk($sformatf("tbl%0d_rd_en", i), 64'(rd_en), 64'(tbl[i].en));
            chk($sformatf("tbl%0d_lane0", i), 64'(rd_addr[7:0]), 64'(tbl[i].a0));
            chk($sformatf("tbl%0d_lane3", i), 64'(rd_addr[31:24]), 64'(tbl[i].a3));
            chk($sformatf("tbl%0d_wr", i), 64'(wr_active), 64'(tbl[i].wr));
            chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].bz));
            chk($sformatf("tbl%0d_done", i), 64'(done), 64'(tbl[i].dn));
            step();
        end

        // stall for two cycles at t=1
        sc = cyc;
        cycle(1, 8'h10, 8'd3, 0, 0);
        cycle(0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 1, 0);
            chk("stall_rd_en", 64'(rd_en), 64'(0));
            chk("stall_wr", 64'(wr_active), 64'(0));
            chk("stall_busy", 64'(busy), 64'(1));
            step();
        end
        drive(0, 0, 0, 0, 0);
        chk("resume_rd_en", 64'(rd_en), 64'(4'b0011));
        chk("resume_lane0", 64'(rd_addr[7:0]), 64'(8'h11));
        step();
        wait_done(sc, 14, "stall_done_lat");
        cycle(0, 0, 0, 0, 0);

        // start with len=0 is ignored
        cycle(1, 8'h20, 8'd0, 0, 0);
        drive(0, 0, 0, 0, 0);
        chk("len0_busy", 64'(busy), 64'(0));
        step();

        // start request during RUN is ignored
        sc = cyc;
        cycle(1, 8'h10, 8'd3, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(1, 8'h80, 8'd7, 0, 0);
        drive(0, 0, 0, 0, 0);
        chk("midrun_lane0", 64'(rd_addr[7:0]), 64'(8'h12));
        step();
        wait_done(sc, 12, "midrun_done_lat");
        cycle(0, 0, 0, 0, 0);

        // reset at t=2 aborts without done
        cycle(1, 8'h10, 8'd3, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        chk("abort_rd_en", 64'(rd_en), 64'(0));
        chk("abort_rd_addr", 64'(rd_addr), 64'(0));
        chk("abort_wr", 64'(wr_active), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        step();
        for (int i = 0; i < 12; i++) cycle(0, 0, 0, 0, 0);
        sc = cyc;
        cycle(1, 8'h40, 8'd3, 0, 0);
        drive(0, 0, 0, 0, 0);
        chk("restart_lane0", 64'(rd_addr[7:0]), 64'(8'h40));
        chk("restart_rd_en", 64'(rd_en), 64'(4'b0001));
        step();
        wait_done(sc, 12, "restart_done_lat");
        cycle(0, 0, 0, 0, 0);

        // address wrap inside a lane
        sc = cyc;
        wcount = 0;
        cycle(1, 8'hFE, 8'd4, 0, 0);
        for (int i = 0; i < 40; i++) begin
            drive(0, 0, 0, 0, 0);
            k = cyc - sc - 1;
            if (k == 0) chk("wrap_l0_t0", 64'(rd_addr[7:0]), 64'(8'hFE));
            if (k == 1) chk("wrap_l0_t1", 64'(rd_addr[7:0]), 64'(8'hFF));
            if (k == 2) chk("wrap_l0_t2", 64'(rd_addr[7:0]), 64'(8'h00));
            if (k == 2) chk("wrap_l1_t2", 64'(rd_addr[15:8]), 64'(8'hFF));
            if (k == 3) chk("wrap_l0_t3", 64'(rd_addr[7:0]), 64'(8'h01));
            if (k == 3) chk("wrap_l3_t3", 64'(rd_addr[31:24]), 64'(8'hFE));
            if (k == 4) chk("wrap_l1_t4", 64'(rd_addr[15:8]), 64'(8'h01));
            if (wr_active) wcount++;
            if (done) begin
                step();
                break;
            end
            step();
        end
        chk("wrap_wr_count", 64'(wcount), 64'(7));
        cycle(0, 0, 0, 0, 0);

        // active held high: back-to-back runs
        rise1 = -1; rise2 = -1; done1 = -1;
        prev_busy = 1'b0;
        for (int i = 0; i < 32; i++) begin
            drive(1, 8'h10, 8'd3, 0, 0);
            if (busy && !prev_busy) begin
                if (rise1 < 0) rise1 = cyc;
                else if (rise2 < 0) rise2 = cyc;
            end
            if (done && done1 < 0) done1 = cyc;
            prev_busy = busy;
            step();
        end
        chk("b2b_restart_gap", 64'(rise2 - rise1), 64'(13));
        chk("b2b_done_after_rise", 64'(done1 - rise1), 64'(11));
        for (int i = 0; i < 16; i++) cycle(0, 0, 0, 0, 0);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic       a, s, r;
            logic [7:0] b, l;
            r = ($urandom_range(0, 99) < 2);
            a = ($urandom_range(0, 3) == 0);
            s = ($urandom_range(0, 4) == 0);
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) l = 8'd0;
            else if ($urandom_range(0, 29) == 0) l = 8'($urandom_range(1, 255));
            else l = 8'($urandom_range(1, 6));
            cycle(a, b, l, s, r);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
